ssd1306_spi_arbiter: RTL and testbench

//  Shares the single 8-bit SPI master that drives the SSD1306 OLED between two requesters:
//  the command sequencer (init, addressing and contrast commands) and the pixel streamer (GDDRAM data).

---
 rtl/ssd1306_spi_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_ssd1306_spi_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_spi_arbiter.sv
// ---------------------------------------------------------------------------
// ssd1306_spi_arbiter
//   Shares the single 8-bit SPI master driving the SSD1306 OLED between the
//   command sequencer (init/addressing/contrast) and the pixel streamer
//   (GDDRAM data). Owns the oled_dc pin, locks the SPI master for a whole
//   packet and spaces writes on spi_done.
//
// Parameters
//   DC_SETUP     cycles oled_dc is stable before the first spi_wr of a packet
//   TIMEOUT_CYC  cycles allowed in WAIT for spi_done before the packet aborts
//   MAX_CMD_PKTS consecutive cmd grants tolerated while pix_req is pending
//                (starvation guard only)
//
// Build option
//   STARVE_GUARD_EN  when defined, pix is forced through after MAX_CMD_PKTS
//                    back-to-back cmd grants; otherwise cmd always wins.
//
// Ports
//   clk_50M, rst_n                 clock, async active-low reset
//   cmd_req/byte/dc/last, cmd_ack  command requester handshake
//   pix_req/byte/last, pix_ack     pixel requester handshake (D/C always 1)
//   spi_wr, spi_data, spi_done     SPI master strobe, byte, completion pulse
//   oled_dc                        D/C pin to the panel
//   owner                          00 none, 01 cmd, 10 pix
//   timeout_err                    1-cycle pulse on SPI timeout abort
// ---------------------------------------------------------------------------
module ssd1306_spi_arbiter #(
    parameter int DC_SETUP     = 2,
    parameter int TIMEOUT_CYC  = 65535,
    parameter int MAX_CMD_PKTS = 4
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       cmd_req,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_dc,
    input  logic       cmd_last,
    output logic       cmd_ack,
    input  logic       pix_req,
    input  logic [7:0] pix_byte,
    input  logic       pix_last,
    output logic       pix_ack,
    output logic       spi_wr,
    output logic [7:0] spi_data,
    input  logic       spi_done,
    output logic       oled_dc,
    output logic [1:0] owner,
    output logic       timeout_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CMD  = 2'b01;
    localparam logic [1:0] OWN_PIX  = 2'b10;

    if (DC_SETUP < 1 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535 ||
        MAX_CMD_PKTS < 1 || MAX_CMD_PKTS > 7) begin : g_param_check
        $error("ssd1306_spi_arbiter: parameter out of range");
    end

    logic [2:0]  state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic        dc_q, dc_d;
    logic [15:0] cnt_q, cnt_d;      // shared: SETUP spacing and WAIT timeout
    logic        last_q, last_d;
    logic        wr_q, wr_d;
    logic [7:0]  data_q, data_d;
    logic        cack_q, cack_d;
    logic        pack_q, pack_d;
    logic        tmo_q, tmo_d;

    logic        pick_pix;
    logic        own_req;
    logic [7:0]  own_byte;
    logic        own_last;
    logic        do_load;

    assign own_req  = (owner_q == OWN_CMD) ? cmd_req  : pix_req;
    assign own_byte = (owner_q == OWN_CMD) ? cmd_byte : pix_byte;
    assign own_last = (owner_q == OWN_CMD) ? cmd_last : pix_last;

`ifdef STARVE_GUARD_EN
    logic [2:0] starve_q, starve_d;

    // Pix wins a tie only once cmd has taken MAX_CMD_PKTS grants in a row
    // while pix was already waiting.
    assign pick_pix = pix_req && (!cmd_req || starve_q == 3'(MAX_CMD_PKTS));

    always_comb begin
        starve_d = starve_q;
        if (state_q == S_IDLE && (cmd_req || pix_req)) begin
            if (pick_pix)     starve_d = 3'd0;
            else if (pix_req) starve_d = starve_q + 3'd1;
            else              starve_d = 3'd0;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) starve_q <= 3'd0;
        else        starve_q <= starve_d;
    end
`else
    assign pick_pix = pix_req && !cmd_req;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        dc_d    = dc_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        cack_d  = 1'b0;
        pack_d  = 1'b0;
        tmo_d   = 1'b0;
        do_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_req || pix_req) begin
                    state_d = S_SETUP;
                    cnt_d   = 16'd0;
                    owner_d = pick_pix ? OWN_PIX : OWN_CMD;
                    dc_d    = pick_pix ? 1'b1 : cmd_dc;
                end
            end
            S_SETUP: begin
                // Spacing counts from the grant edge, so the first write
                // lands DC_SETUP+1 cycles after it. An owner that has
                // dropped req by then is simply waited for.
                if (cnt_q == 16'(DC_SETUP)) begin
                    if (own_req) do_load = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
                cnt_d   = 16'd0;
            end
            S_WAIT: begin
                if (spi_done) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        owner_d = OWN_NONE;
                    end else if (own_req) begin
                        do_load = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_HOLD: begin
                if (own_req) do_load = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        // Strobe, byte and ack are registered on the edge entering LOAD so
        // all three appear together for exactly the LOAD cycle.
        if (do_load) begin
            state_d = S_LOAD;
            wr_d    = 1'b1;
            data_d  = own_byte;
            last_d  = own_last;
            cack_d  = (owner_q == OWN_CMD);
            pack_d  = (owner_q == OWN_PIX);
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= OWN_NONE;
            dc_q    <= 1'b0;
            cnt_q   <= 16'd0;
            last_q  <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= 8'd0;
            cack_q  <= 1'b0;
            pack_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            dc_q    <= dc_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            cack_q  <= cack_d;
            pack_q  <= pack_d;
            tmo_q   <= tmo_d;
        end
    end

    assign cmd_ack     = cack_q;
    assign pix_ack     = pack_q;
    assign spi_wr      = wr_q;
    assign spi_data    = data_q;
    assign oled_dc     = dc_q;
    assign owner       = owner_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_ssd1306_spi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ssd1306_spi_arbiter
//   Directed bench for ssd1306_spi_arbiter: a packet table for single-owner
//   transfers, then hand sequences for tie arbitration, HOLD, timeout,
//   mid-packet reset and cmd/pix fairness. Requesters and the SPI master are
//   modelled as byte queues and a fixed-latency spi_done responder.
// ---------------------------------------------------------------------------
module tb_ssd1306_spi_arbiter;

    localparam int DC_SETUP = 2;
    localparam int TMO      = 16;
    localparam int MAXC     = 4;

    logic       clk_50M = 1'b0;
    logic       rst_n   = 1'b0;
    logic       cmd_req = 1'b0, cmd_dc = 1'b0, cmd_last = 1'b0, cmd_ack;
    logic [7:0] cmd_byte = 8'h00;
    logic       pix_req = 1'b0, pix_last = 1'b0, pix_ack;
    logic [7:0] pix_byte = 8'h00;
    logic       spi_wr, spi_done = 1'b0, oled_dc, timeout_err;
    logic [7:0] spi_data;
    logic [1:0] owner;

    always #5 clk_50M = ~clk_50M;

    ssd1306_spi_arbiter #(
        .DC_SETUP    (DC_SETUP),
        .TIMEOUT_CYC (TMO),
        .MAX_CMD_PKTS(MAXC)
    ) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .cmd_req    (cmd_req),
        .cmd_byte   (cmd_byte),
        .cmd_dc     (cmd_dc),
        .cmd_last   (cmd_last),
        .cmd_ack    (cmd_ack),
        .pix_req    (pix_req),
        .pix_byte   (pix_byte),
        .pix_last   (pix_last),
        .pix_ack    (pix_ack),
        .spi_wr     (spi_wr),
        .spi_data   (spi_data),
        .spi_done   (spi_done),
        .oled_dc    (oled_dc),
        .owner      (owner),
        .timeout_err(timeout_err)
    );

    typedef struct {
        int         cyc;
        logic [1:0] own;
        logic       dc;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        bit              pix;
        logic            dc;
        int              n;
        logic [2:0][7:0] b;      // b[0] is sent first
        logic [1:0]      exp_own;
        logic            exp_dc;
    } vec_t;

    wr_t        wr_log[$];
    int         grant_cyc[$];
    logic [1:0] grant_own[$];
    int         rel_cyc[$];
    int         tmo_cyc[$];
    logic [8:0] cq[$];           // {last, byte}
    logic [8:0] pq[$];
    logic       cdc = 1'b0;
    logic [1:0] prev_own = 2'b00;
    int cyc = 0, nvec = 0, nerr = 0;
    int cack_n = 0, pack_n = 0;
    int done_dly = 10, done_cnt = 0;
    int pix_gap = 0, pix_gap_len = 0, gap_end = -1, gap_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int wr_cyc(input int k);
        return (k < wr_log.size()) ? wr_log[k].cyc : -1000;
    endfunction

    task automatic drive();
        cmd_req  = (cq.size() != 0);
        cmd_byte = cmd_req ? cq[0][7:0] : 8'h00;
        cmd_last = cmd_req ? cq[0][8]   : 1'b0;
        cmd_dc   = cdc;
        pix_req  = (pq.size() != 0) && (pix_gap == 0);
        pix_byte = (pq.size() != 0) ? pq[0][7:0] : 8'h00;
        pix_last = (pq.size() != 0) ? pq[0][8]   : 1'b0;
    endtask

    task automatic clear_logs();
        wr_log.delete(); grant_cyc.delete(); grant_own.delete();
        rel_cyc.delete(); tmo_cyc.delete();
        cack_n = 0; pack_n = 0;
    endtask

    // One clock: observe outputs #1 after the edge, then update the models.
    task automatic step();
        @(posedge clk_50M);
        #1;
        cyc++;
        if (spi_wr) wr_log.push_back('{cyc, owner, oled_dc, spi_data});
        if (prev_own == 2'b00 && owner != 2'b00) begin
            grant_cyc.push_back(cyc);
            grant_own.push_back(owner);
        end
        if (prev_own != 2'b00 && owner == 2'b00) rel_cyc.push_back(cyc);
        prev_own = owner;
        if (timeout_err) begin
            tmo_cyc.push_back(cyc);
            cq.delete();
            pq.delete();
        end
        if (pix_gap > 0) begin
            pix_gap--;
            if (pix_gap == 0) gap_end = cyc;
            if (owner != 2'b10 || cmd_ack) gap_bad++;
        end
        if (cmd_ack) begin
            cack_n++;
            chk("cmd_ack_strobe", {30'd0, spi_wr, owner == 2'b01}, 32'd3);
            if (cq.size() != 0) void'(cq.pop_front());
        end
        if (pix_ack) begin
            pack_n++;
            chk("pix_ack_strobe", {30'd0, spi_wr, owner == 2'b10}, 32'd3);
            if (pq.size() != 0) void'(pq.pop_front());
            if (pix_gap_len > 0) begin
                pix_gap     = pix_gap_len;
                pix_gap_len = 0;
            end
        end
        if (done_cnt > 0) begin
            done_cnt--;
            spi_done = (done_cnt == 0);
        end else begin
            spi_done = 1'b0;
        end
        if (spi_wr && done_dly > 0) done_cnt = done_dly;
        drive();
    endtask

    task automatic run(input int maxc);
        int n;
        n = 0;
        drive();
        while (cq.size() != 0 || pq.size() != 0 || owner != 2'b00) begin
            step();
            n++;
            if (n >= maxc) begin
                nvec++;
                nerr++;
                $display("FAIL run_budget: got %0d cycles, expected fewer than %0d", n, maxc);
                cq.delete();
                pq.delete();
                break;
            end
        end
        repeat (3) step();
    endtask

    vec_t       vt[5];
    logic [1:0] fair[8];

    initial begin
        vt[0] = '{1'b0, 1'b0, 3, 24'h80D5AE, 2'b01, 1'b0};
        vt[1] = '{1'b1, 1'b0, 3, 24'hA500FF, 2'b10, 1'b1};
        vt[2] = '{1'b0, 1'b1, 2, 24'h003412, 2'b01, 1'b1};
        vt[3] = '{1'b0, 1'b0, 1, 24'h000081, 2'b01, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1, 24'h00003C, 2'b10, 1'b1};

        // ---- reset state ----
        drive();
        repeat (3) step();
        chk("rst_owner", owner, 0);
        chk("rst_oled_dc", oled_dc, 0);
        chk("rst_spi_wr", spi_wr, 0);
        chk("rst_spi_data", spi_data, 0);
        chk("rst_acks", {cmd_ack, pix_ack, timeout_err}, 0);
        rst_n = 1'b1;
        repeat (2) step();

        // ---- packet table ----
        for (int v = 0; v < 5; v++) begin
            clear_logs();
            cdc = vt[v].dc;
            for (int k = 0; k < vt[v].n; k++) begin
                if (vt[v].pix) pq.push_back({(k == vt[v].n - 1), vt[v].b[k]});
                else           cq.push_back({(k == vt[v].n - 1), vt[v].b[k]});
            end
            run(400);
            chk("tbl_n_writes", wr_log.size(), vt[v].n);
            for (int k = 0; k < vt[v].n && k < wr_log.size(); k++) begin
                chk("tbl_data", wr_log[k].d, vt[v].b[k]);
                chk("tbl_dc", wr_log[k].dc, vt[v].exp_dc);
                chk("tbl_owner", wr_log[k].own, vt[v].exp_own);
            end
            chk("tbl_grant_to_wr", wr_cyc(0) - (grant_cyc.size() ? grant_cyc[0] : 0), DC_SETUP + 1);
            chk("tbl_acks", vt[v].pix ? pack_n : cack_n, vt[v].n);
            chk("tbl_other_acks", vt[v].pix ? cack_n : pack_n, 0);
            chk("tbl_owner_end", owner, 0);
        end

        // ---- tie: cmd first, pix granted one idle cycle after release ----
        clear_logs();
        cdc = 1'b0;
        cq.push_back({1'b1, 8'hA4});
        pq.push_back({1'b1, 8'h55});
        run(400);
        chk("tie_n_writes", wr_log.size(), 2);
        chk("tie_first_own", wr_log.size() > 0 ? wr_log[0].own : 2'b11, 2'b01);
        chk("tie_second", wr_log.size() > 1 ? {wr_log[1].own, wr_log[1].dc, wr_log[1].d} : 11'h7FF,
            {2'b10, 1'b1, 8'h55});
        chk("tie_regrant_gap", (grant_cyc.size() > 1 && rel_cyc.size() > 0) ? grant_cyc[1] - rel_cyc[0] : -1, 1);
        chk("tie_pix_dc_setup", wr_cyc(1) - (grant_cyc.size() > 1 ? grant_cyc[1] : 0), DC_SETUP + 1);

        // ---- HOLD: pix drops req after byte 1 for 20 cycles, cmd waits ----
        clear_logs();
        gap_bad = 0;
        gap_end = -1;
        pix_gap_len = 20;
        pq.push_back({1'b0, 8'h11});
        pq.push_back({1'b0, 8'h22});
        pq.push_back({1'b1, 8'h33});
        drive();
        step();
        chk("hold_pix_granted", owner, 2'b10);
        cq.push_back({1'b1, 8'h99});
        run(400);
        chk("hold_n_writes", wr_log.size(), 4);
        chk("hold_order", wr_log.size() == 4 ?
            {wr_log[0].d, wr_log[1].d, wr_log[2].d, wr_log[3].d} : 32'hFFFFFFFF, 32'h11223399);
        chk("hold_blocked", gap_bad, 0);
        chk("hold_resume", wr_cyc(1) - gap_end, 1);
        chk("hold_cmd_last", wr_log.size() == 4 ? wr_log[3].own : 2'b11, 2'b01);

        // ---- timeout: spi_done never arrives ----
        clear_logs();
        done_dly = 0;
        cdc = 1'b1;
        cq.push_back({1'b0, 8'h01});
        cq.push_back({1'b1, 8'h02});
        run(200);
        repeat (5) step();
        chk("tmo_pulses", tmo_cyc.size(), 1);
        chk("tmo_latency", (tmo_cyc.size() ? tmo_cyc[0] : 0) - wr_cyc(0), TMO + 1);
        chk("tmo_owner_cleared", (rel_cyc.size() ? rel_cyc[0] : -1) - (tmo_cyc.size() ? tmo_cyc[0] : 0), 0);
        chk("tmo_dropped", wr_log.size(), 1);
        done_dly = 10;

        // ---- reset during WAIT of byte 2 ----
        clear_logs();
        cdc = 1'b1;
        cq.push_back({1'b0, 8'h10});
        cq.push_back({1'b0, 8'h20});
        cq.push_back({1'b1, 8'h30});
        drive();
        for (int n = 0; n < 100 && wr_log.size() < 2; n++) step();
        chk("rstw_reached", wr_log.size(), 2);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("rstw_owner", owner, 0);
        chk("rstw_oled_dc", oled_dc, 0);
        chk("rstw_spi_data", spi_data, 0);
        chk("rstw_strobes", {spi_wr, cmd_ack, pix_ack, timeout_err}, 0);
        cq.delete();
        done_cnt = 0;
        spi_done = 1'b0;
        clear_logs();
        drive();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (12) step();
        chk("rstw_no_wr", wr_log.size(), 0);
        chk("rstw_no_ack", cack_n + pack_n, 0);

        // ---- fairness: both requesters always busy with 1-byte packets ----
`ifdef STARVE_GUARD_EN
        fair = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
`else
        fair = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
`endif
        clear_logs();
        cdc = 1'b0;
        for (int k = 0; k < 6; k++) cq.push_back({1'b1, 8'hC0 + 8'(k)});
        pq.push_back({1'b1, 8'hB0});
        pq.push_back({1'b1, 8'hB1});
        run(1000);
        chk("fair_n_writes", wr_log.size(), 8);
        for (int k = 0; k < 8 && k < wr_log.size(); k++)
            chk("fair_owner", wr_log[k].own, fair[k]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
